// File: rtl/dpot_multi.sv
// Multi-channel SPI write engine for DPOT-class digital potentiometers.
// One shared MOSI/SCLK pair, one active-low chip select per device, round-robin service of pending channels.
module dpot_multi #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 8,
  parameter int HALF_DIV = 2,
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DATA_W-1:0] value,
  input  logic [CHANNELS-1:0]        update,
  input  logic                       auto_en,
  output logic [CHANNELS-1:0]        nCS,
  output logic                       SCLK,
  output logic                       MOSI,
  output logic [CHANNELS-1:0]        pending,
  output logic                       ready,
  output logic                       done,
  output logic [AW-1:0]              active_ch
);

  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              sclk_hi;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] last_sent [CHANNELS];
  logic [DATA_W-1:0] vals      [CHANNELS];
  logic [AW-1:0]     ptr;

  logic [CHANNELS-1:0] diff;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] clr;
  logic                sel_found;
  logic [AW-1:0]       sel_idx;
  logic [DATA_W-1:0]   sel_value;
  logic                div_last;
  logic                framing;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      vals[k] = value[k*DATA_W +: DATA_W];
      diff[k] = (vals[k] != last_sent[k]);
    end
  end

  // Search starts one past the last served channel so every requester gets a turn.
  always_comb begin
    int            idx;
    logic [AW-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_value = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      cand = idx[AW-1:0];
      if (!sel_found && pending[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_value = vals[cand];
      end
    end
  end

  // The channel being captured already matches its value, so its auto request is masked;
  // an explicit update in the same cycle still re-arms it.
  always_comb begin
    clr = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      clr[k] = (state == IDLE) && sel_found && (sel_idx == AW'(k));
    end
    req = update | (auto_en ? (diff & ~clr) : '0);
  end

  assign div_last = (div_cnt == DW'(HALF_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sclk_hi   <= 1'b0;
      shift     <= '0;
      pending   <= '0;
      ptr       <= AW'(CHANNELS - 1);
      active_ch <= '0;
      for (int k = 0; k < CHANNELS; k++) last_sent[k] <= vals[k];
    end else begin
      pending <= (pending & ~clr) | req;
      case (state)
        IDLE: begin
          if (sel_found) begin
            state              <= SETUP;
            div_cnt            <= '0;
            shift              <= sel_value;
            last_sent[sel_idx] <= sel_value;
            active_ch          <= sel_idx;
            ptr                <= sel_idx;
          end
        end
        SETUP: begin
          if (div_last) begin
            state   <= SHIFT;
            div_cnt <= '0;
            sclk_hi <= 1'b1;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (sclk_hi) begin
              sclk_hi <= 1'b0;
              shift   <= shift << 1;
            end else if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sclk_hi <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (div_last) begin
            state   <= IDLE;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign framing = (state == SETUP) || (state == SHIFT);

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      nCS[k] = !(framing && (active_ch == AW'(k)));
    end
  end

  assign SCLK  = (state == SHIFT) && sclk_hi;
  assign MOSI  = framing && shift[DATA_W-1];
  assign done  = (state == HOLD) && div_last;
  assign ready = (state == IDLE) && (pending == '0);

endmodule

// File: tb/tb_dpot_multi.sv
// Bench for dpot_multi: SPI bus monitor with an expected-frame queue, plus a
// single-channel fast instance for the parameter corner.
module tb_dpot_multi;

  localparam int CH = 4;
  localparam int DW = 8;
  localparam int HD = 2;
  localparam int AW = 2;
  localparam int W  = AW + DW;
  localparam int P_LEN = HD * (1 + 2 * DW);
  localparam int P_PER = 1 + HD * (2 + 2 * DW);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic [DW-1:0]    vals [CH];
  logic [DW-1:0]    next_vals [CH];
  logic [CH*DW-1:0] value;
  logic [CH-1:0]    update;
  logic             auto_en;
  logic [CH-1:0]    nCS;
  logic             SCLK, MOSI, ready, done;
  logic [CH-1:0]    pending;
  logic [AW-1:0]    active_ch;

  always_comb begin
    value = '0;
    for (int k = 0; k < CH; k++) value[k*DW +: DW] = vals[k];
  end

  dpot_multi #(.CHANNELS(CH), .DATA_W(DW), .HALF_DIV(HD)) u_dut (
    .clk(clk), .rst(rst), .value(value), .update(update), .auto_en(auto_en),
    .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI), .pending(pending), .ready(ready),
    .done(done), .active_ch(active_ch)
  );

  // single-channel instance: HALF_DIV=1, DATA_W=10
  logic [9:0] value1;
  logic [0:0] update1, nCS1, pending1, active_ch1;
  logic       auto1, SCLK1, MOSI1, ready1, done1;

  dpot_multi #(.CHANNELS(1), .DATA_W(10), .HALF_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .value(value1), .update(update1), .auto_en(auto1),
    .nCS(nCS1), .SCLK(SCLK1), .MOSI(MOSI1), .pending(pending1), .ready(ready1),
    .done(done1), .active_ch(active_ch1)
  );

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] model_last [CH];
  int            rr_ptr;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor for the main instance
  logic          in_frame = 1'b0, await_done = 1'b0, fr_bad, idle_bad = 1'b0;
  logic          prev_sclk, prev_mosi;
  logic [AW-1:0] fr_ch, last_ch;
  logic [DW-1:0] fr_data;
  logic [CH-1:0] cs_low;
  logic [W-1:0]  exp_v;
  int            fr_len, fr_bits, hold_cnt;
  int            last_fall = -1, prev_fall = -1, frames = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame   = 1'b0;
      await_done = 1'b0;
      prev_sclk  = 1'b0;
      prev_mosi  = 1'b0;
    end else begin
      cs_low = ~nCS;
      if (!in_frame && cs_low != '0) begin
        in_frame = 1'b1;
        for (int k = 0; k < CH; k++) if (cs_low[k]) fr_ch = AW'(k);
        fr_data = '0; fr_bits = 0; fr_len = 0; fr_bad = 1'b0;
        prev_fall = last_fall;
        last_fall = cyc;
      end
      if (in_frame) begin
        if (cs_low != '0) begin
          fr_len++;
          if (cs_low != (CH'(1) << fr_ch)) fr_bad = 1'b1;
          if (SCLK && !prev_sclk) begin
            fr_data = {fr_data[DW-2:0], MOSI};
            fr_bits++;
          end
          if (SCLK && prev_sclk && (MOSI !== prev_mosi)) fr_bad = 1'b1;
        end else begin
          in_frame = 1'b0;
          frames++;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", {fr_ch, fr_data}, '1);
          end else begin
            exp_v = exp_q.pop_front();
            check("frame_ch_data", {fr_ch, fr_data}, exp_v);
          end
          check("cs_low_len", fr_len, P_LEN);
          check("bit_count", fr_bits, DW);
          check("frame_shape", fr_bad, 0);
          last_ch    = fr_ch;
          await_done = 1'b1;
          hold_cnt   = 1;
        end
      end else begin
        if (SCLK || MOSI) idle_bad = 1'b1;
        if (await_done) hold_cnt++;
      end
      if (done) begin
        check("done_expected", await_done, 1);
        check("done_spacing", hold_cnt, HD);
        check("active_ch_at_done", active_ch, last_ch);
        await_done = 1'b0;
      end
      prev_sclk = SCLK;
      prev_mosi = MOSI;
    end
  end

  // monitor for the single-channel instance
  logic       in1 = 1'b0, prev_sclk1;
  logic [9:0] data1;
  int         len1, bits1, last_fall1 = -1, frames1 = 0;

  always @(negedge clk) begin
    if (rst) begin
      in1 = 1'b0;
      prev_sclk1 = 1'b0;
    end else begin
      if (!in1 && !nCS1[0]) begin
        in1 = 1'b1; len1 = 0; bits1 = 0; data1 = '0;
        if (last_fall1 >= 0) check("period_p1", cyc - last_fall1, 23);
        last_fall1 = cyc;
      end
      if (in1) begin
        if (!nCS1[0]) begin
          len1++;
          if (SCLK1 && !prev_sclk1) begin
            data1 = {data1[8:0], MOSI1};
            bits1++;
          end
        end else begin
          in1 = 1'b0;
          frames1++;
          check("p1_data", data1, value1);
          check("p1_bits", bits1, 10);
          check("p1_cs_len", len1, 21);
        end
      end
      prev_sclk1 = SCLK1;
    end
  end

  // driver tasks and reference model
  task automatic model_reset();
    rr_ptr = CH - 1;
    for (int k = 0; k < CH; k++) model_last[k] = vals[k];
  endtask

  // Requests raised together while idle are served in channel order starting after the last served one.
  task automatic model_issue(input logic [CH-1:0] reqs);
    int idx, last;
    last = rr_ptr;
    for (int i = 1; i <= CH; i++) begin
      idx = (rr_ptr + i) % CH;
      if (reqs[idx]) begin
        exp_q.push_back({idx[AW-1:0], vals[idx]});
        model_last[idx] = vals[idx];
        last = idx;
      end
    end
    rr_ptr = last;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", ready, 1);
  endtask

  task automatic wait_cs(input int ch, input int budget);
    int n = 0;
    while (nCS[ch] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cs_fall_within_budget", nCS[ch], 0);
  endtask

  task automatic apply(input logic [CH-1:0] mask, input logic a);
    logic [CH-1:0] reqs;
    @(negedge clk);
    for (int k = 0; k < CH; k++) vals[k] = next_vals[k];
    update  = mask;
    auto_en = a;
    reqs = mask;
    if (a) for (int k = 0; k < CH; k++) if (vals[k] != model_last[k]) reqs[k] = 1'b1;
    model_issue(reqs);
    @(negedge clk);
    update = '0;
    repeat (2) @(negedge clk);
    wait_idle(3000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int rises, n, f0;
    logic prev_s;
    update  = '0;
    auto_en = 1'b0;
    update1 = '0;
    auto1   = 1'b0;
    value1  = 10'($urandom_range(0, 1023));
    for (int k = 0; k < CH; k++) vals[k] = DW'($urandom_range(0, 255));

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ncs", nCS, 4'hF);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_pending", pending, 0);
    check("rst_done", done, 0);
    check("rst_active_ch", active_ch, 0);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("ready_after_reset", ready, 1);

    // round robin: 1011 then 0011, pointer wraps from ch3
    for (int k = 0; k < CH; k++) next_vals[k] = vals[k];
    apply(4'b1011, 1'b0);
    check("rr_period", last_fall - prev_fall, P_PER);
    apply(4'b0011, 1'b0);
    check("rr_period_wrap", last_fall - prev_fall, P_PER);

    // single write with latency checks
    do_reset();
    @(negedge clk);
    vals[2] = 8'hA5;
    update  = 4'b0100;
    model_issue(4'b0100);
    @(negedge clk);
    check("lat_pending_set", pending, 4'b0100);
    check("lat_ncs_still_high", nCS, 4'hF);
    check("lat_ready_low", ready, 0);
    update = '0;
    @(negedge clk);
    check("lat_ncs_low", nCS, 4'b1011);
    check("lat_pending_clear", pending, 0);
    wait_idle(500);
    check("single_active_ch", active_ch, 2);

    // auto mode
    for (int k = 0; k < CH; k++) next_vals[k] = vals[k];
    next_vals[1] = 8'h10;
    apply(4'b0010, 1'b0);
    @(negedge clk);
    auto_en = 1'b1;
    repeat (10) @(negedge clk);
    check("auto_quiet_unchanged", ready, 1);
    vals[1] = 8'h80;
    exp_q.push_back({2'd1, 8'h80});
    wait_cs(1, 20);
    repeat (8) @(negedge clk);
    vals[1] = 8'h40;
    exp_q.push_back({2'd1, 8'h40});
    model_last[1] = 8'h40;
    rr_ptr = 1;
    repeat (2) @(negedge clk);
    wait_idle(500);
    check("auto_queue_drained", exp_q.size(), 0);
    auto_en = 1'b0;
    vals[1] = 8'h33;
    vals[3] = vals[3] ^ 8'hFF;
    repeat (60) @(negedge clk);
    check("auto_off_no_frame", ready, 1);

    // collision: update[0] still high when ch0 is selected
    @(negedge clk);
    update = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    check("collision_cs", nCS, 4'b1110);
    check("collision_pending", pending, 4'b0001);
    update = '0;
    model_issue(4'b0001);
    exp_q.push_back({2'd0, vals[0]});
    wait_idle(500);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < CH; k++)
        next_vals[k] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 255)) : vals[k];
      apply(CH'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // reset mid-frame at bit 4
    for (int k = 0; k < CH; k++) next_vals[k] = vals[k];
    apply(4'b0000, 1'b1);
    @(negedge clk);
    update = 4'b1000;
    @(negedge clk);
    update = '0;
    wait_cs(3, 20);
    rises = 0; n = 0; prev_s = 1'b0;
    while (rises < 5 && n < 200) begin
      if (SCLK && !prev_s) rises++;
      prev_s = SCLK;
      if (rises < 5) @(negedge clk);
      n++;
    end
    check("reached_bit4", rises, 5);
    rst = 1'b1;
    f0 = frames;
    @(negedge clk);
    check("abort_ncs", nCS, 4'hF);
    check("abort_sclk", SCLK, 0);
    check("abort_mosi", MOSI, 0);
    check("abort_pending", pending, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (60) @(negedge clk);
    check("no_frame_after_reset", frames - f0, 0);
    check("ready_after_abort", ready, 1);

    // single-channel fast instance, update held high
    @(negedge clk);
    update1 = 1'b1;
    repeat (50) @(negedge clk);
    update1 = 1'b0;
    n = 0;
    while ((!ready1 || n < 2) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("p1_idle", ready1, 1);
    check("p1_frames", frames1, 4);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("idle_bus_quiet", idle_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
